// File: rtl/ps2_kbd_command_sequencer.sv
// ps2_kbd_command_sequencer
//
// Brings a PS/2 keyboard up through its command handshake (reset FF -> ACK FA
// -> self-test AA, then set-LEDs ED -> ACK -> LED byte -> ACK). It then
// services runtime LED updates and forwards ordinary scan-code bytes. Resend
// (FE), self-test failure (FC) and response timeouts are retried a bounded
// number of times before the block parks in a sticky ERROR state.
//
// Ports
//   CLOCK_50              in   system clock
//   reset                 in   synchronous, active-high reset
//   led_state[2:0]        in   {caps, num, scroll}, sampled on led_update_req
//   led_update_req        in   single-cycle request to push led_state
//   ps2_command[7:0]      out  command byte to the transceiver
//   ps2_send_command      out  transceiver send request
//   ps2_command_was_sent  in   transceiver done flag (held while send is high)
//   ps2_error_timeout     in   transceiver timeout flag (held while send is high)
//   ps2_received_data[7:0] in  received byte
//   ps2_received_data_en  in   one-cycle strobe for ps2_received_data
//   key_data[7:0]         out  forwarded scan-code byte
//   key_data_valid        out  one-cycle pulse qualifying key_data
//   init_done             out  keyboard initialised (READY and later LED updates)
//   busy                  out  combinational, high whenever not READY
//   error                 out  sticky, high in ERROR

module ps2_kbd_command_sequencer #(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int BAT_TIMEOUT = 50000000,
    parameter int MAX_RETRIES = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] led_state,
    input  logic       led_update_req,
    output logic [7:0] ps2_command,
    output logic       ps2_send_command,
    input  logic       ps2_command_was_sent,
    input  logic       ps2_error_timeout,
    input  logic [7:0] ps2_received_data,
    input  logic       ps2_received_data_en,
    output logic [7:0] key_data,
    output logic       key_data_valid,
    output logic       init_done,
    output logic       busy,
    output logic       error
);

    localparam int TIMER_LIMIT = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int TW          = $clog2(TIMER_LIMIT + 1);
    localparam int RW          = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LAST   = TW'(BAT_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_SAT  = TW'(TIMER_LIMIT);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        S_GAP,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_BAT,
        S_READY,
        S_ERROR
    } state_e;

    // Which command of the handshake is in flight; selects what an ACK means.
    typedef enum logic [1:0] {
        STEP_RST,
        STEP_LEDCMD,
        STEP_LEDVAL
    } step_e;

    state_e          state_q;
    step_e           step_q;
    logic [7:0]      cmd_q;
    logic            send_q;
    logic [TW-1:0]   timer_q;
    logic [RW-1:0]   retry_q;
    logic            pending_q;
    logic [2:0]      led_q;
    logic [7:0]      key_data_q;
    logic            key_valid_q;
    logic            init_done_q;
    logic            error_q;

    logic            rx_ack;
    logic            rx_bat_ok;
    logic            retry_evt;

    assign rx_ack    = ps2_received_data_en && (ps2_received_data == RSP_ACK);
    assign rx_bat_ok = ps2_received_data_en && (ps2_received_data == RSP_BAT_OK);

    // A received byte takes priority over a timer expiry in the same cycle;
    // because the timer saturates, an expiry masked by an unrelated byte
    // still fires on the next cycle.
    always_comb begin
        // NOTE: default first so every path assigns retry_evt and no latch is inferred.
        retry_evt = 1'b0;
        case (state_q)
            S_SEND:     retry_evt = ps2_error_timeout && !ps2_command_was_sent;
            S_WAIT_ACK: retry_evt = ps2_received_data_en ? (ps2_received_data == RSP_RESEND)
                                                         : (timer_q >= ACK_LAST);
            S_WAIT_BAT: retry_evt = ps2_received_data_en ? (ps2_received_data == RSP_BAT_FAIL)
                                                         : (timer_q >= BAT_LAST);
            default:    retry_evt = 1'b0;
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values;
    // later assignments in this block deliberately override earlier ones.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_GAP;
            step_q      <= STEP_RST;
            cmd_q       <= CMD_RESET;
            send_q      <= 1'b0;
            timer_q     <= '0;
            retry_q     <= '0;
            pending_q   <= 1'b0;
            led_q       <= 3'b000;
            key_data_q  <= 8'h00;
            key_valid_q <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;

            // Timer runs only while awaiting a response; zero everywhere else.
            if (state_q == S_WAIT_ACK || state_q == S_WAIT_BAT) begin
                if (timer_q != TIMER_SAT) timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end

            case (state_q)
                S_GAP: begin
                    // Wait for the transceiver to drop its flags from the last send.
                    if (!ps2_command_was_sent && !ps2_error_timeout) begin
                        state_q <= S_SEND;
                        send_q  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (ps2_command_was_sent) begin
                        state_q <= S_WAIT_ACK;
                        send_q  <= 1'b0;
                        timer_q <= '0;
                    end
                end
                S_WAIT_ACK: begin
                    if (rx_ack) begin
                        retry_q <= '0;
                        timer_q <= '0;
                        case (step_q)
                            STEP_RST: state_q <= S_WAIT_BAT;
                            STEP_LEDCMD: begin
                                cmd_q   <= {5'b00000, led_q};
                                step_q  <= STEP_LEDVAL;
                                state_q <= S_GAP;
                            end
                            default: begin
                                state_q     <= S_READY;
                                init_done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WAIT_BAT: begin
                    if (rx_bat_ok) begin
                        cmd_q   <= CMD_SET_LEDS;
                        step_q  <= STEP_LEDCMD;
                        state_q <= S_GAP;
                        timer_q <= '0;
                    end
                end
                S_READY: begin
                    if (ps2_received_data_en) begin
                        // AA here means the keyboard was replugged: restore its LEDs.
                        if (ps2_received_data == RSP_BAT_OK) begin
                            pending_q <= 1'b1;
                        end else begin
                            key_data_q  <= ps2_received_data;
                            key_valid_q <= 1'b1;
                        end
                    end
                    if (pending_q) begin
                        pending_q <= 1'b0;
                        cmd_q     <= CMD_SET_LEDS;
                        step_q    <= STEP_LEDCMD;
                        state_q   <= S_GAP;
                    end
                end
                default: ; // S_ERROR: parked until reset
            endcase

            // A request arriving in the dispatch cycle re-arms pending so it is not lost.
            if (led_update_req && state_q != S_ERROR) begin
                led_q     <= led_state;
                pending_q <= 1'b1;
            end

            if (retry_evt) begin
                send_q  <= 1'b0;
                timer_q <= '0;
                if (retry_q < RETRY_MAX) begin
                    retry_q <= retry_q + 1'b1;
                    state_q <= S_GAP;
                end else begin
                    state_q     <= S_ERROR;
                    error_q     <= 1'b1;
                    init_done_q <= 1'b0;
                end
            end
        end
    end

    assign ps2_command      = cmd_q;
    assign ps2_send_command = send_q;
    assign key_data         = key_data_q;
    assign key_data_valid   = key_valid_q;
    assign init_done        = init_done_q;
    assign error            = error_q;
    assign busy             = reset || (state_q != S_READY);

endmodule

// File: tb/tb_ps2_kbd_command_sequencer.sv
// Self-checking bench for ps2_kbd_command_sequencer. A single process drives
// all inputs on the falling edge: it models the PS/2 transceiver (was_sent
// after a configurable delay) and the keyboard (auto-responses), and checks
// sent commands and forwarded key bytes against scoreboard queues that the
// test steps fill as they drive stimulus.

module tb_ps2_kbd_command_sequencer;

    localparam int ACK_TO     = 1000;
    localparam int BAT_TO     = 2000;
    localparam int RETRIES    = 3;
    localparam int RESP_DELAY = 20;

    logic       CLOCK_50;
    logic       reset;
    logic [2:0] led_state;
    logic       led_update_req;
    logic [7:0] ps2_command;
    logic       ps2_send_command;
    logic       ps2_command_was_sent;
    logic       ps2_error_timeout;
    logic [7:0] ps2_received_data;
    logic       ps2_received_data_en;
    logic [7:0] key_data;
    logic       key_data_valid;
    logic       init_done;
    logic       busy;
    logic       error;

    ps2_kbd_command_sequencer #(
        .ACK_TIMEOUT(ACK_TO),
        .BAT_TIMEOUT(BAT_TO),
        .MAX_RETRIES(RETRIES)
    ) dut (
        .CLOCK_50             (CLOCK_50),
        .reset                (reset),
        .led_state            (led_state),
        .led_update_req       (led_update_req),
        .ps2_command          (ps2_command),
        .ps2_send_command     (ps2_send_command),
        .ps2_command_was_sent (ps2_command_was_sent),
        .ps2_error_timeout    (ps2_error_timeout),
        .ps2_received_data    (ps2_received_data),
        .ps2_received_data_en (ps2_received_data_en),
        .key_data             (key_data),
        .key_data_valid       (key_data_valid),
        .init_done            (init_done),
        .busy                 (busy),
        .error                (error)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } key_exp_t;

    typedef struct {
        logic       inj;
        logic [7:0] rx;
        logic       req;
        logic [2:0] leds;
        logic       fwd;
        logic       seq;
        logic [7:0] led_byte;
    } vec_t;

    int         n_cmp;
    int         n_bad;
    int         ncyc;
    logic [7:0] exp_cmd_q[$];
    key_exp_t   exp_key_q[$];
    logic [7:0] resp_q[$];
    int         xcv_delay;
    int         xcv_cnt;
    int         send_low;
    int         resp_wait;
    int         fe_budget;
    int         n_sends;
    int         n_valid;
    int         n_stuck_viol;
    int         last_was_cyc;
    logic       kbd_silent;
    logic       stuck_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive the models.
    task automatic tick();
        key_exp_t k;
        @(negedge CLOCK_50);
        ncyc++;

        if (key_data_valid) begin
            n_valid++;
            if (exp_key_q.size() == 0) begin
                check("key_valid_unexpected", 32'(key_data_valid), 32'd0);
            end else begin
                k = exp_key_q.pop_front();
                check("key_data", 32'(key_data), 32'(k.data));
                check("key_latency", 32'(ncyc - k.cyc), 32'd1);
            end
        end
        if (stuck_flags && ps2_send_command) n_stuck_viol++;

        led_update_req       = 1'b0;
        ps2_received_data_en = 1'b0;

        // Transceiver model.
        if (stuck_flags) begin
            ps2_command_was_sent = 1'b1;
            ps2_error_timeout    = 1'b0;
            xcv_cnt              = 0;
        end else if (reset || !ps2_send_command) begin
            ps2_command_was_sent = 1'b0;
            ps2_error_timeout    = 1'b0;
            xcv_cnt              = 0;
            send_low++;
        end else if (!ps2_command_was_sent) begin
            if (xcv_cnt == 0) begin
                n_sends++;
                check("cmd_gap", 32'(send_low >= 1), 32'd1);
                send_low = 0;
                if (exp_cmd_q.size() == 0)
                    check("cmd_unexpected_send", 32'(ps2_send_command), 32'd0);
                else
                    check("cmd_byte", 32'(ps2_command), 32'(exp_cmd_q.pop_front()));
            end
            xcv_cnt++;
            if (xcv_cnt >= xcv_delay) begin
                ps2_command_was_sent = 1'b1;
                last_was_cyc         = ncyc;
                // Keyboard model reacts to the completed command.
                if (!kbd_silent) begin
                    if (fe_budget > 0 && ps2_command == 8'hED) begin
                        resp_q.push_back(8'hFE);
                        fe_budget--;
                    end else begin
                        resp_q.push_back(8'hFA);
                        if (ps2_command == 8'hFF) resp_q.push_back(8'hAA);
                    end
                    resp_wait = RESP_DELAY;
                end
            end
        end

        // Keyboard byte delivery.
        if (reset) begin
            resp_q.delete();
        end else if (resp_q.size() > 0) begin
            if (resp_wait > 0) begin
                resp_wait--;
            end else begin
                ps2_received_data    = resp_q.pop_front();
                ps2_received_data_en = 1'b1;
                resp_wait            = RESP_DELAY;
            end
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        ps2_received_data    = b;
        ps2_received_data_en = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick();
        tick();
        while ((busy || exp_cmd_q.size() > 0 || exp_key_q.size() > 0 || resp_q.size() > 0)
               && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_init(input int budget);
        int n;
        n = 0;
        while (!init_done && n < budget) begin
            tick();
            n++;
        end
        check("init_done_reached", 32'(init_done), 32'd1);
    endtask

    initial begin
        vec_t     vecs[6];
        key_exp_t ke;
        int       n;
        int       valid_snap;

        n_cmp = 0; n_bad = 0; ncyc = 0;
        xcv_delay = 100; xcv_cnt = 0; send_low = 100; resp_wait = 0;
        fe_budget = 0; n_sends = 0; n_valid = 0; n_stuck_viol = 0; last_was_cyc = 0;
        kbd_silent = 1'b0; stuck_flags = 1'b0;
        reset = 1'b1; led_state = 3'b000; led_update_req = 1'b0;
        ps2_command_was_sent = 1'b0; ps2_error_timeout = 1'b0;
        ps2_received_data = 8'h00; ps2_received_data_en = 1'b0;

        // Runtime READY vectors: {inj, rx, req, leds, fwd, seq, led_byte}.
        vecs[0] = '{1'b1, 8'h1C, 1'b1, 3'b101, 1'b1, 1'b1, 8'h05}; // strobe + request together
        vecs[1] = '{1'b1, 8'h2B, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00}; // plain scan code
        vecs[2] = '{1'b1, 8'hAA, 1'b0, 3'b000, 1'b0, 1'b1, 8'h05}; // hot-plug: current LEDs
        vecs[3] = '{1'b0, 8'h00, 1'b1, 3'b011, 1'b0, 1'b1, 8'h03}; // request only
        vecs[4] = '{1'b1, 8'hFA, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00}; // FA is data in READY
        vecs[5] = '{1'b1, 8'hF0, 1'b1, 3'b111, 1'b1, 1'b1, 8'h07};

        // Reset state.
        repeat (3) tick();
        check("rst_send",      32'(ps2_send_command), 32'd0);
        check("rst_command",   32'(ps2_command),      32'hFF);
        check("rst_key_data",  32'(key_data),         32'h00);
        check("rst_key_valid", 32'(key_data_valid),   32'd0);
        check("rst_init_done", 32'(init_done),        32'd0);
        check("rst_error",     32'(error),            32'd0);
        check("rst_busy",      32'(busy),             32'd1);

        // Normal init: FF, ED, 00 with the transceiver taking 100 cycles per byte.
        exp_cmd_q.push_back(8'hFF);
        exp_cmd_q.push_back(8'hED);
        exp_cmd_q.push_back(8'h00);
        reset = 1'b0;
        wait_init(5000);
        wait_idle(500);
        check("init_busy",      32'(busy),              32'd0);
        check("init_cmds_left", 32'(exp_cmd_q.size()),  32'd0);
        check("init_error",     32'(error),             32'd0);

        // Resend: first ED answered with FE, so ED goes twice before the LED byte.
        xcv_delay = 10;
        fe_budget = 1;
        tick();
        led_state = 3'b010;
        led_update_req = 1'b1;
        exp_cmd_q.push_back(8'hED);
        exp_cmd_q.push_back(8'hED);
        exp_cmd_q.push_back(8'h02);
        wait_idle(3000);
        check("resend_error",     32'(error),             32'd0);
        check("resend_cmds_left", 32'(exp_cmd_q.size()),  32'd0);
        check("resend_init_done", 32'(init_done),         32'd1);

        // Runtime forwarding and LED updates from the vector table.
        for (int i = 0; i < 6; i++) begin
            tick();
            if (vecs[i].req) begin
                led_state      = vecs[i].leds;
                led_update_req = 1'b1;
            end
            if (vecs[i].inj) begin
                drive_byte(vecs[i].rx);
                if (vecs[i].fwd) begin
                    ke.data = vecs[i].rx;
                    ke.cyc  = ncyc;
                    exp_key_q.push_back(ke);
                end
            end
            if (vecs[i].seq) begin
                exp_cmd_q.push_back(8'hED);
                exp_cmd_q.push_back(vecs[i].led_byte);
            end
            wait_idle(3000);
            check("vec_busy",  32'(busy),  32'd0);
            check("vec_error", 32'(error), 32'd0);
        end
        valid_snap = n_valid;
        check("vec_valid_count", 32'(valid_snap), 32'd4);

        // Reset while ED is being sent; transceiver flags then stick high.
        xcv_delay = 400;
        tick();
        led_state = 3'b110;
        led_update_req = 1'b1;
        exp_cmd_q.push_back(8'hED);
        n = 0;
        while (!ps2_send_command && n < 100) begin
            tick();
            n++;
        end
        check("midsend_send_seen", 32'(ps2_send_command), 32'd1);
        reset = 1'b1;
        tick();
        check("midsend_send_dropped", 32'(ps2_send_command), 32'd0);
        check("midsend_init_done",    32'(init_done),        32'd0);
        check("midsend_busy",         32'(busy),             32'd1);
        stuck_flags = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        n_stuck_viol = 0;
        repeat (30) tick();
        check("midsend_gap_held", 32'(n_stuck_viol), 32'd0);
        exp_cmd_q.push_back(8'hFF);
        exp_cmd_q.push_back(8'hED);
        exp_cmd_q.push_back(8'h00);
        xcv_delay = 10;
        stuck_flags = 1'b0;
        wait_init(5000);
        wait_idle(500);
        check("midsend_cmds_left", 32'(exp_cmd_q.size()), 32'd0);
        check("midsend_busy_idle", 32'(busy),             32'd0);

        // Retry exhaustion: keyboard never answers FF.
        reset = 1'b1;
        repeat (2) tick();
        kbd_silent = 1'b1;
        n_sends = 0;
        for (int i = 0; i < 1 + RETRIES; i++) exp_cmd_q.push_back(8'hFF);
        reset = 1'b0;
        n = 0;
        while (!error && n < 8000) begin
            tick();
            n++;
        end
        check("exh_error",      32'(error), 32'd1);
        check("exh_delay",      32'((ncyc - last_was_cyc) == ACK_TO || (ncyc - last_was_cyc) == ACK_TO + 1), 32'd1);
        check("exh_sends",      32'(n_sends), 32'(1 + RETRIES));
        check("exh_cmds_left",  32'(exp_cmd_q.size()), 32'd0);
        check("exh_init_done",  32'(init_done), 32'd0);
        valid_snap = n_valid;
        tick();
        drive_byte(8'h1C);
        led_state = 3'b101;
        led_update_req = 1'b1;
        repeat (300) tick();
        check("exh_no_forward", 32'(n_valid - valid_snap), 32'd0);
        check("exh_sticky",     32'(error),   32'd1);
        check("exh_busy",       32'(busy),    32'd1);
        check("exh_no_send",    32'(n_sends), 32'(1 + RETRIES));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_command_sequencer.md
Name: ps2_kbd_command_sequencer

Overview:
- Sits between the game logic and the PS/2 transceiver. It sequences keyboard bring-up: reset command FF, then ACK FA, then self-test pass AA, then set-LEDs ED, then ACK, then LED byte, then ACK.
- After bring-up it services runtime LED-update requests and forwards ordinary scan-code bytes downstream.
- It handles resend (FE) and response timeouts with bounded retries, and flags a sticky error.

Parameters:
- ACK_TIMEOUT, 1000000: cycles to wait for FA/FE after a command is sent (20 ms at 50 MHz).
- BAT_TIMEOUT, 50000000: cycles to wait for AA/FC after the FF command is ACKed (1 s).
- MAX_RETRIES, 3: resend attempts per command before entering ERROR.

Ports:
- CLOCK_50 in 1: system clock.
- reset in 1: synchronous, active-high.
- led_state in 3: {caps, num, scroll}, sampled on a request.
- led_update_req in 1: single-cycle request to push led_state to the keyboard.
- ps2_command out 8: command byte to the transceiver.
- ps2_send_command out 1: transceiver send request.
- ps2_command_was_sent in 1: transceiver done flag; stays high while send is held.
- ps2_error_timeout in 1: transceiver timeout flag; stays high while send is held.
- ps2_received_data in 8: received byte.
- ps2_received_data_en in 1: one-cycle strobe qualifying ps2_received_data.
- key_data out 8: forwarded scan-code byte.
- key_data_valid out 1: one-cycle pulse qualifying key_data.
- init_done out 1: high in READY and during LED updates after the first successful init.
- busy out 1: combinational, high when state != READY.
- error out 1: sticky, high in ERROR.

Behaviour:
- Reset, synchronous, active-high on CLOCK_50.
  - Outputs after reset: ps2_send_command=0, ps2_command=FF, key_data=00, key_data_valid=0, init_done=0, error=0.
  - Internal: retry count=0, pending=0, led_reg=000.
  - State goes to GAP with cmd_reg=FF and step=RST.
  - Reset mid-operation drops ps2_send_command on the same edge and restarts the full init.
- All outputs except busy are registered. cmd_reg drives ps2_command.
- GAP: hold ps2_send_command=0 until ps2_command_was_sent=0 and ps2_error_timeout=0, then go to SEND. The minimum gap is 1 cycle.
- SEND: ps2_send_command=1.
  - ps2_command_was_sent=1 leads to WAIT_ACK, dropping send and clearing the timer. This has priority over a simultaneous timeout.
  - ps2_error_timeout=1 (was_sent=0) triggers a retry.
- WAIT_ACK: the timer counts 0..ACK_TIMEOUT-1. On ps2_received_data_en:
  - FA: clear retries, then advance by step.
    - RST goes to WAIT_BAT.
    - LEDCMD sets cmd_reg={5'b0,led_reg} and step=LEDVAL, then GAP.
    - LEDVAL goes to READY and sets init_done=1.
  - FE: retry.
  - Any other byte: dropped.
  - Timer expiry: retry.
- WAIT_BAT: the timer counts to BAT_TIMEOUT-1.
  - AA: set cmd_reg=ED and step=LEDCMD, then GAP.
  - FC: retry.
  - Timer expiry: retry.
  - Other bytes are dropped.
- Retry:
  - If retries < MAX_RETRIES: retries+1 and GAP with the same cmd_reg.
  - For step=LEDVAL, the same LED byte is resent, not ED.
  - Otherwise go to ERROR.
- ERROR: send=0, error=1, busy=1. Leaves only on reset. Received bytes are not forwarded.
- READY:
  - Data forwarding: on ps2_received_data_en with a byte other than AA, register key_data=byte and pulse key_data_valid the next cycle (latency 1).
  - AA in READY (hot-plug): set pending=1, do not forward.
  - Sampling: led_update_req=1 in any state other than ERROR latches led_reg<=led_state and sets pending=1. A later request overwrites led_reg, so last value wins.
  - Dispatch: in READY with pending=1, clear pending, set cmd_reg=ED and step=LEDCMD, then GAP.
  - Simultaneous events: if a strobe and a request arrive in the same READY cycle, the byte is forwarded and pending is set. The LED sequence starts on the following cycle.
- Scan-code bytes arriving while not in READY are dropped. This is accepted behaviour.
- Timers: width $clog2(max(ACK_TIMEOUT,BAT_TIMEOUT)+1). They are zeroed on every state entry and saturate at the limit.
- Retry counter: width $clog2(MAX_RETRIES+1).
- busy is 1 during reset.

Test Plan:
- Normal init:
  - Stimulus: release reset; model ACKs ps2_command=FF with was_sent after 100 cycles, returns FA then AA, ACKs ED with FA, ACKs 00 with FA.
  - Required: exactly commands FF, ED, 00 in order; send low ≥1 cycle between commands; init_done=1; busy=0.
- Resend:
  - Stimulus: answer the first ED with FE, then FA.
  - Required: ED is sent twice, then 00 is sent; error=0.
- Retry exhaustion:
  - Stimulus: ACK_TIMEOUT=1000; model never responds to FF.
  - Required: FF is sent 4 times (1 + MAX_RETRIES); ERROR is entered 1000 cycles after the 4th was_sent; error=1 stays sticky; key bytes are no longer forwarded.
- Runtime LEDs and forwarding:
  - Stimulus: in READY, pulse led_update_req with led_state=101 in the same cycle as received byte 1C.
  - Required: key_data=1C with key_data_valid pulsed 1 cycle after the strobe; then ED and 05 sent, each ACKed; busy returns to 0.
- Hot-plug:
  - Stimulus: AA received in READY.
  - Required: no key_data_valid; ED followed by the current led_reg is sent.
- Reset mid-SEND:
  - Stimulus: assert reset while ps2_send_command=1.
  - Required: send=0 on the next edge; init_done=0; after release, FF is re-sent once the transceiver flags are low.
